// File: rtl/block_config_pkg.sv
// block_config_pkg
// Shared definitions for the CLB configuration path: the loader state
// encoding and the default LUT / block-count sizing used by the CLB top.
package block_config_pkg;

  localparam int DEFAULT_MEM_SIZE   = 16;
  localparam int DEFAULT_NUM_BLOCKS = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    COMMIT = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } load_state_t;

endpackage

// File: rtl/block_config_loader_shift_reg.sv
// config_shift_reg
// LSB-first serial-to-parallel assembler for one LUT word.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   clear      - restart word assembly (partial bits and count dropped)
//   shift_en   - accept bit_in this cycle
//   bit_in     - serial configuration bit
//   word_next  - the word as it will look once bit_in is accepted
//   full       - this accept completes a MEM_SIZE-bit word
module config_shift_reg #(
  parameter int MEM_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                shift_en,
  input  logic                bit_in,
  output logic [MEM_SIZE-1:0] word_next,
  output logic                full
);

  localparam int CNT_BITS = (MEM_SIZE > 2) ? $clog2(MEM_SIZE) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MEM_SIZE - 1);

  // Only MEM_SIZE-1 bits are stored: on the completing accept the oldest bit
  // would fall out of a full-width register anyway, so the finished word is
  // formed combinationally from the stored bits plus the incoming one.
  logic [MEM_SIZE-2:0] partial;
  logic [CNT_BITS-1:0] cnt;

  assign word_next = {bit_in, partial};
  assign full      = shift_en && (cnt == CNT_LAST);

  // New bits enter at the MSB and walk down, so the first accepted bit ends
  // at bit 0 of the completed word. The count wraps on the completing accept.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      partial <= '0;
      cnt     <= '0;
    end else if (shift_en) begin
      partial <= word_next[MEM_SIZE-1:1];
      cnt     <= full ? '0 : cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/block_config_loader.sv
// block_config_loader
// Front end of the CLB configuration path. Assembles serial config bits into
// MEM_SIZE-bit LUT words and strobes each target block's latches in turn.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   start       - begin a full load of all blocks (honoured only when idle)
//   bit_in      - serial configuration bit, LSB of each word first
//   bit_valid   - bit_in carries a bit
//   bit_ready   - loader takes the offered bit this cycle
//   config_out  - parallel word shared by all target blocks
//   comb_set    - one-hot capture strobe, bit i for block i
//   busy        - a load is in progress
//   done        - one-cycle pulse once the final block is committed
module block_config_loader
  import block_config_pkg::*;
#(
  parameter int MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter int NUM_BLOCKS = DEFAULT_NUM_BLOCKS,
  parameter int BLK_BITS   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] comb_set,
  output logic                  busy,
  output logic                  done
);

  localparam logic [BLK_BITS-1:0] BLK_LAST = BLK_BITS'(NUM_BLOCKS - 1);

  load_state_t         state;
  load_state_t         state_next;
  logic [BLK_BITS-1:0] blk;
  logic                shift_en;
  logic                shift_clear;
  logic                word_full;
  logic [MEM_SIZE-1:0] word_next;

  assign shift_en = (state == SHIFT) && bit_valid;

  config_shift_reg #(
    .MEM_SIZE (MEM_SIZE)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clear     (shift_clear),
    .shift_en  (shift_en),
    .bit_in    (bit_in),
    .word_next (word_next),
    .full      (word_full)
  );

  // State register, block index and the shared output word. config_out only
  // moves on the edge that completes a word, i.e. the edge entering COMMIT,
  // so it is settled for the whole strobe cycle and the HOLD cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      blk        <= '0;
      config_out <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        blk <= '0;
      end else if (state == HOLD && blk != BLK_LAST) begin
        blk <= blk + BLK_BITS'(1);
      end
      if (word_full) begin
        config_out <= word_next;
      end
    end
  end

  // Next-state and Moore outputs. Strobe and handshake depend on state only,
  // so a reset edge clears them for the following cycle even mid-COMMIT.
  always_comb begin
    state_next  = state;
    bit_ready   = 1'b0;
    comb_set    = '0;
    busy        = 1'b1;
    done        = 1'b0;
    shift_clear = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next  = SHIFT;
          shift_clear = 1'b1;
        end
      end
      SHIFT: begin
        bit_ready = 1'b1;
        if (word_full) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        comb_set   = NUM_BLOCKS'(1) << blk;
        state_next = HOLD;
      end
      HOLD: begin
        state_next = (blk == BLK_LAST) ? DONE : SHIFT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/block_config_loader.md
# block_config_loader

- Front end of the CLB configuration path.
- Accepts a serial configuration bitstream, assembles each MEM_SIZE-bit LUT word and presents it on a shared `config_out` bus.
- Pulses the per-block `comb_set` strobe that captures the word into that block's config latches.
- Loads NUM_BLOCKS targets in ascending index order per `start`, then reports `done`.

## Interface
- MEM_SIZE, 16, config bits per target block (LUT size, 2**ADDR_BITS)
- NUM_BLOCKS, 4, number of target latch blocks
- BLK_BITS, $clog2(NUM_BLOCKS) (1 if NUM_BLOCKS==1), block index width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset: synchronous, active-high
- start  in  1  begin a full load; sampled only in IDLE
- bit_in  in  1  serial config bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  loader accepts a bit this cycle
- config_out  out  MEM_SIZE  parallel word to all target blocks
- comb_set  out  NUM_BLOCKS  one-hot capture strobe, bit i for block i
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final block is committed

## Operation
- States: IDLE, SHIFT, COMMIT, HOLD, DONE.
- IDLE:
  - bit_ready=0, comb_set=0.
  - start=1 -> SHIFT with blk=0, bit counter=0.
- SHIFT:
  - bit_ready=1.
  - On each edge with bit_valid&&bit_ready: shift register takes {bit_in, sr[MEM_SIZE-1:1]} and the counter increments.
  - First accepted bit therefore ends up at config_out[0] (LSB first).
  - On the MEM_SIZE-th accept: config_out loads the completed word (counter wraps to 0) -> COMMIT.
- COMMIT:
  - comb_set[blk]=1 for exactly one cycle, all other bits 0.
  - config_out stable.
  - bit_ready=0.
  - -> HOLD.
- HOLD:
  - comb_set=0; config_out still stable (hold margin for level-sensitive latches).
  - If blk==NUM_BLOCKS-1 -> DONE; else blk+1 -> SHIFT.
- DONE:
  - done=1 for one cycle -> IDLE.
- start is ignored when not in IDLE. Bits offered outside SHIFT are not consumed.
- config_out changes only on the edge entering COMMIT; it keeps the last word after DONE.
- comb_set is never asserted while config_out is changing, and never asserted in SHIFT.

## Timing
- Reset values:
  - state=IDLE; config_out=0, comb_set=0, bit_ready=0, busy=0, done=0.
  - Shift register, counter and blk = 0.
- Reset mid-operation: on the edge where rst=1, all outputs reach reset values, including comb_set mid-COMMIT. The partial word is discarded; no resumption.
- start sampled at edge 0 -> bit_ready=1 and busy=1 from cycle 1.
- With bit_valid held high, each block takes MEM_SIZE+2 cycles. Default parameters: 18 cycles per block.
- done is high in cycle NUM_BLOCKS*(MEM_SIZE+2)+1 after the start edge. Default parameters: cycle 73.
- bit_valid gaps stall SHIFT only: the counter holds and no timeout applies.
- start together with rst: rst wins and the load does not begin.

## Structure
- Shared package `block_config_pkg`:
  - state enum (IDLE, SHIFT, COMMIT, HOLD, DONE), 3-bit encoding.
  - Default MEM_SIZE and NUM_BLOCKS constants, shared with the CLB top.
- One sub-module, `config_shift_reg`:
  - MEM_SIZE-bit LSB-first shift register with a shift enable.
  - Counter and full flag at MEM_SIZE accepts.
- FSM, block index, config_out register and one-hot comb_set decode sit in `block_config_loader`.

## Test plan
- Basic load:
  - Stimulus: defaults, start, continuous valid, words 0x0001, 0x8000, 0xA5A5, 0xFFFF.
  - Response: comb_set = 0001, 0010, 0100, 1000 each one cycle, with config_out equal to the matching word; done at cycle 73.
- Bit order:
  - Stimulus: first bit=1, remaining 15 bits=0 for block 0.
  - Response: config_out=0x0001 in COMMIT.
- Valid gaps:
  - Stimulus: bit_valid low every other cycle.
  - Response: same words committed; done at cycle 4*(32+2)+1=137.
- Reset mid-COMMIT:
  - Stimulus: rst during block 2 COMMIT.
  - Response: next cycle comb_set=0, config_out=0, busy=0; block 2 is not re-strobed.
- Start while busy:
  - Stimulus: pulse start during SHIFT of block 1.
  - Response: ignored; exactly 4 comb_set pulses total, one done.
- Back-to-back loads:
  - Stimulus: start asserted in the cycle after done.
  - Response: second load begins, blk restarts at 0, config_out keeps 0xFFFF until the first COMMIT.
